compactador_imediato: RTL and testbench

- Inverse of the processor's immediate sign-extension path: takes a 32-bit value, narrows it to a signed 16-bit or 21-bit immediate field, and flags any value that does not fit.
- Used by the instruction-build/patch datapath (bootloader, branch-offset fix-up) before the field is written into an instruction word.
- Two-stage valid/ready pipeline with a saturating overflow-event counter.
- Round-trip contract: whenever sai_estouro=0, sign-extending sai_campo under the same ctrl reproduces ent_valor exactly.

---
 rtl/compactador_imediato_pkg.sv | 28 ++
 rtl/compactador_imediato_verifica_faixa.sv | 43 ++++
 rtl/compactador_imediato.sv | 99 +++++++++
 tb/tb_compactador_imediato.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/compactador_imediato_pkg.sv
// Shared immediate-field definitions: ctrl encodings, field widths, clamp limits and payload types.
package pacote_imediato;

    localparam int unsigned LARG_VALOR  = 32;
    localparam int unsigned LARG_IMED16 = 16;
    localparam int unsigned LARG_IMED21 = 21;
    localparam int unsigned LARG_CAMPO  = 21;

    localparam logic CTRL_IMED16 = 1'b1;
    localparam logic CTRL_IMED21 = 1'b0;

    localparam logic [LARG_CAMPO-1:0] MAX16 = 21'h007FFF;
    localparam logic [LARG_CAMPO-1:0] MIN16 = 21'h008000;
    localparam logic [LARG_CAMPO-1:0] MAX21 = 21'h0FFFFF;
    localparam logic [LARG_CAMPO-1:0] MIN21 = 21'h100000;

    typedef struct packed {
        logic [LARG_VALOR-1:0] valor;
        logic                  ctrl;
    } entrada_t;

    typedef struct packed {
        logic [LARG_CAMPO-1:0] campo;
        logic                  ctrl;
        logic                  estouro;
    } resultado_t;

endpackage

// File: rtl/compactador_imediato_verifica_faixa.sv
// Combinational fit check of a 32-bit value against the selected signed field, with truncate or clamp.
module verifica_faixa
    import pacote_imediato::*;
#(
    parameter bit SATURA = 1'b0
) (
    input  logic [LARG_VALOR-1:0] valor,
    input  logic                  ctrl,
    output logic [LARG_CAMPO-1:0] campo_c,
    output logic                  estouro_c
);

    logic [LARG_VALOR-LARG_IMED16:0] topo16;
    logic [LARG_VALOR-LARG_IMED21:0] topo21;
    logic                            cabe;
    logic                            negativo;

    always_comb begin
        topo16   = valor[LARG_VALOR-1:LARG_IMED16-1];
        topo21   = valor[LARG_VALOR-1:LARG_IMED21-1];
        negativo = valor[LARG_VALOR-1];
        cabe     = 1'b0;
        campo_c  = '0;

        // A value fits when every bit above the field's sign bit copies the sign
        if (ctrl == CTRL_IMED16) begin
            cabe    = (&topo16) | ~(|topo16);
            campo_c = LARG_CAMPO'(valor[LARG_IMED16-1:0]);
            if (SATURA && !cabe) begin
                campo_c = negativo ? MIN16 : MAX16;
            end
        end else begin
            cabe    = (&topo21) | ~(|topo21);
            campo_c = valor[LARG_IMED21-1:0];
            if (SATURA && !cabe) begin
                campo_c = negativo ? MIN21 : MAX21;
            end
        end

        estouro_c = !cabe;
    end

endmodule

// File: rtl/compactador_imediato.sv
// Two-stage valid/ready narrower from 32-bit values to signed 16/21-bit immediate fields,
// with a saturating count of overflowing results.
module compactador_imediato
    import pacote_imediato::*;
#(
    parameter bit          SATURA    = 1'b0,
    parameter int unsigned LARG_CONT = 8
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  ent_valido,
    output logic                  ent_pronto,
    input  logic [LARG_VALOR-1:0] ent_valor,
    input  logic                  ent_ctrl,
    output logic                  sai_valido,
    input  logic                  sai_pronto,
    output logic [LARG_CAMPO-1:0] sai_campo,
    output logic                  sai_ctrl,
    output logic                  sai_estouro,
    output logic [LARG_CONT-1:0]  cont_estouro,
    input  logic                  limpa_cont
);

    logic                 v1_q, v1_d;
    logic                 v2_q, v2_d;
    entrada_t             ent1_q, ent1_d;
    resultado_t           res_q, res_d;
    logic [LARG_CONT-1:0] cont_q, cont_d;

    logic                  avanca1_c;
    logic                  transf_ent_c;
    logic                  transf_sai_c;
    logic [LARG_CAMPO-1:0] campo_c;
    logic                  estouro_c;

    verifica_faixa #(.SATURA(SATURA)) u_verifica_faixa (
        .valor     (ent1_q.valor),
        .ctrl      (ent1_q.ctrl),
        .campo_c   (campo_c),
        .estouro_c (estouro_c)
    );

    always_comb begin
        avanca1_c    = v1_q && (!v2_q || sai_pronto);
        ent_pronto   = !v1_q || avanca1_c;
        transf_ent_c = ent_valido && ent_pronto;
        transf_sai_c = v2_q && sai_pronto;

        v1_d   = v1_q;
        ent1_d = ent1_q;
        v2_d   = v2_q;
        res_d  = res_q;
        cont_d = cont_q;

        if (transf_ent_c) begin
            v1_d   = 1'b1;
            ent1_d = '{valor: ent_valor, ctrl: ent_ctrl};
        end else if (avanca1_c) begin
            v1_d = 1'b0;
        end

        // S2 refills from S1 or empties once its result is taken; otherwise it holds
        if (avanca1_c) begin
            v2_d  = 1'b1;
            res_d = '{campo: campo_c, ctrl: ent1_q.ctrl, estouro: estouro_c};
        end else if (transf_sai_c) begin
            v2_d = 1'b0;
        end

        if (limpa_cont) begin
            cont_d = '0;
        end else if (transf_sai_c && res_q.estouro && (cont_q != {LARG_CONT{1'b1}})) begin
            cont_d = cont_q + LARG_CONT'(1);
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            v1_q   <= 1'b0;
            v2_q   <= 1'b0;
            ent1_q <= '0;
            res_q  <= '0;
            cont_q <= '0;
        end else begin
            v1_q   <= v1_d;
            v2_q   <= v2_d;
            ent1_q <= ent1_d;
            res_q  <= res_d;
            cont_q <= cont_d;
        end
    end

    assign sai_valido   = v2_q;
    assign sai_campo    = res_q.campo;
    assign sai_ctrl     = res_q.ctrl;
    assign sai_estouro  = res_q.estouro;
    assign cont_estouro = cont_q;

endmodule

// File: tb/tb_compactador_imediato.sv
// Scoreboard bench for compactador_imediato: one truncating and one clamping instance share stimulus.
module tb_compactador_imediato;

    typedef struct packed {
        logic [31:0] v;
        logic        c;
        logic [20:0] e0;
        logic [20:0] e1;
        logic        est;
    } vec_t;

    logic        clock;
    logic        reset;
    logic        ent_valido;
    logic [31:0] ent_valor;
    logic        ent_ctrl;
    logic        sai_pronto;
    logic        limpa_cont;

    logic        ent_pronto0, ent_pronto1;
    logic        sai_valido0, sai_valido1;
    logic [20:0] sai_campo0, sai_campo1;
    logic        sai_ctrl0, sai_ctrl1;
    logic        sai_estouro0, sai_estouro1;
    logic [7:0]  cont0, cont1;

    int   pass_cnt  = 0;
    int   total_cnt = 0;
    vec_t sb[$];
    vec_t tab[10];
    vec_t mon_it;
    logic mon_xfer;
    logic [7:0]  cnt_exp;
    logic [31:0] ext;
    logic [20:0] snap;

    compactador_imediato #(.SATURA(1'b0), .LARG_CONT(8)) u_dut0 (
        .clock(clock), .reset(reset), .ent_valido(ent_valido), .ent_pronto(ent_pronto0),
        .ent_valor(ent_valor), .ent_ctrl(ent_ctrl), .sai_valido(sai_valido0),
        .sai_pronto(sai_pronto), .sai_campo(sai_campo0), .sai_ctrl(sai_ctrl0),
        .sai_estouro(sai_estouro0), .cont_estouro(cont0), .limpa_cont(limpa_cont)
    );

    compactador_imediato #(.SATURA(1'b1), .LARG_CONT(8)) u_dut1 (
        .clock(clock), .reset(reset), .ent_valido(ent_valido), .ent_pronto(ent_pronto1),
        .ent_valor(ent_valor), .ent_ctrl(ent_ctrl), .sai_valido(sai_valido1),
        .sai_pronto(sai_pronto), .sai_campo(sai_campo1), .sai_ctrl(sai_ctrl1),
        .sai_estouro(sai_estouro1), .cont_estouro(cont1), .limpa_cont(limpa_cont)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string nome, input logic [31:0] got, input logic [31:0] exp);
        total_cnt++;
        if (got !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h", nome, got, exp);
        else pass_cnt++;
    endtask

    // Reference for random vectors only; directed vectors carry hand-computed results
    function automatic vec_t modelo(input logic [31:0] v, input logic c);
        vec_t        r;
        logic        fits;
        logic [20:0] t;
        if (c) fits = (v[31:15] == 17'h1FFFF) || (v[31:15] == 17'h0);
        else   fits = (v[31:20] == 12'hFFF) || (v[31:20] == 12'h0);
        t = c ? {5'b0, v[15:0]} : v[20:0];
        r.v   = v;
        r.c   = c;
        r.est = !fits;
        r.e0  = t;
        if (fits)   r.e1 = t;
        else if (c) r.e1 = v[31] ? 21'h008000 : 21'h007FFF;
        else        r.e1 = v[31] ? 21'h100000 : 21'h0FFFFF;
        return r;
    endfunction

    task automatic send(input vec_t it);
        ent_valido = 1'b1;
        ent_valor  = it.v;
        ent_ctrl   = it.c;
        for (int n = 0; n < 100; n++) begin
            @(negedge clock);
            if (ent_pronto0) begin
                sb.push_back(it);
                @(posedge clock);
                #1;
                ent_valido = 1'b0;
                return;
            end
        end
        total_cnt++;
        $display("FAIL send_timeout: got ent_pronto=0 expected 1 within 100 cycles");
        ent_valido = 1'b0;
    endtask

    task automatic drain();
        for (int n = 0; n < 60; n++) begin
            @(negedge clock);
            if (sb.size() == 0) break;
        end
        chk("drain_empty", 32'(sb.size()), 32'd0);
        @(posedge clock);
        #1;
    endtask

    // Monitor: pops on every output transfer, tracks the expected counter
    always @(negedge clock) begin
        if (!reset) begin
            cnt_exp = 8'd0;
        end else begin
            chk("cont_estouro0", 32'(cont0), 32'(cnt_exp));
            chk("cont_estouro1", 32'(cont1), 32'(cnt_exp));
            mon_xfer = 1'b0;
            if (sai_valido0 && sai_pronto) begin
                if (sb.size() == 0) begin
                    total_cnt++;
                    $display("FAIL unexpected_output: got campo 0x%0h expected no output", sai_campo0);
                end else begin
                    mon_it   = sb.pop_front();
                    mon_xfer = 1'b1;
                    chk("valido1",  32'(sai_valido1),  32'd1);
                    chk("campo0",   32'(sai_campo0),   32'(mon_it.e0));
                    chk("campo1",   32'(sai_campo1),   32'(mon_it.e1));
                    chk("estouro0", 32'(sai_estouro0), 32'(mon_it.est));
                    chk("estouro1", 32'(sai_estouro1), 32'(mon_it.est));
                    chk("ctrl0",    32'(sai_ctrl0),    32'(mon_it.c));
                    chk("ctrl1",    32'(sai_ctrl1),    32'(mon_it.c));
                    if (!mon_it.est) begin
                        ext = sai_ctrl0 ? {{16{sai_campo0[15]}}, sai_campo0[15:0]}
                                        : {{11{sai_campo0[20]}}, sai_campo0};
                        chk("round_trip", ext, mon_it.v);
                    end
                end
            end
            if (limpa_cont) cnt_exp = 8'd0;
            else if (mon_xfer && mon_it.est && cnt_exp != 8'hFF) cnt_exp = cnt_exp + 8'd1;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        tab[0] = '{32'hFFFF8000, 1'b1, 21'h008000, 21'h008000, 1'b0};
        tab[1] = '{32'h000FFFFF, 1'b0, 21'h0FFFFF, 21'h0FFFFF, 1'b0};
        tab[2] = '{32'h00100000, 1'b0, 21'h100000, 21'h0FFFFF, 1'b1};
        tab[3] = '{32'h80000000, 1'b1, 21'h000000, 21'h008000, 1'b1};
        tab[4] = '{32'h00010000, 1'b1, 21'h000000, 21'h007FFF, 1'b1};
        tab[5] = '{32'h00007FFF, 1'b1, 21'h007FFF, 21'h007FFF, 1'b0};
        tab[6] = '{32'hFFF00000, 1'b0, 21'h100000, 21'h100000, 1'b0};
        tab[7] = '{32'hFFEFFFFF, 1'b0, 21'h0FFFFF, 21'h100000, 1'b1};
        tab[8] = '{32'h12345678, 1'b1, 21'h005678, 21'h007FFF, 1'b1};
        tab[9] = '{32'h00000000, 1'b0, 21'h000000, 21'h000000, 1'b0};

        reset      = 1'b0;
        ent_valido = 1'b0;
        ent_valor  = 32'd0;
        ent_ctrl   = 1'b0;
        sai_pronto = 1'b1;
        limpa_cont = 1'b0;
        #2;
        chk("rst_valido0",  32'(sai_valido0),  32'd0);
        chk("rst_valido1",  32'(sai_valido1),  32'd0);
        chk("rst_campo0",   32'(sai_campo0),   32'd0);
        chk("rst_ctrl0",    32'(sai_ctrl0),    32'd0);
        chk("rst_estouro0", 32'(sai_estouro0), 32'd0);
        chk("rst_cont0",    32'(cont0),        32'd0);
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b1;

        // Directed vectors back to back at full throughput
        for (int i = 0; i < 10; i++) send(tab[i]);
        drain();

        // Backpressure: two accepted then stall, outputs hold for three cycles
        sai_pronto = 1'b0;
        send(tab[5]);
        send(tab[6]);
        @(negedge clock);
        chk("bp_ent_pronto", 32'(ent_pronto0), 32'd0);
        snap = sai_campo0;
        @(posedge clock);
        #1;
        fork
            begin
                send(tab[7]);
                send(tab[8]);
            end
        join_none
        repeat (3) begin
            @(negedge clock);
            chk("bp_valido", 32'(sai_valido0), 32'd1);
            chk("bp_stable", 32'(sai_campo0),  32'(snap));
            chk("bp_pronto", 32'(ent_pronto0), 32'd0);
        end
        @(posedge clock);
        #1;
        sai_pronto = 1'b1;
        repeat (4) begin
            @(negedge clock);
            chk("bp_stream", 32'(sai_valido0), 32'd1);
        end
        wait fork;
        drain();

        // Counter saturation, then clear colliding with an overflow transfer
        for (int i = 0; i < 260; i++) send(tab[2]);
        drain();
        @(negedge clock);
        chk("cont_sat", 32'(cont0), 32'd255);
        @(posedge clock);
        #1;
        send(tab[2]);
        @(posedge clock);
        #1;
        limpa_cont = 1'b1;
        @(posedge clock);
        #1;
        limpa_cont = 1'b0;
        sb.delete();
        @(negedge clock);
        chk("cont_clear", 32'(cont0), 32'd0);
        @(posedge clock);
        #1;

        // Asynchronous reset with both stages full
        send(tab[3]);
        drain();
        sai_pronto = 1'b0;
        send(tab[0]);
        send(tab[1]);
        chk("pre_rst_valido", 32'(sai_valido0), 32'd1);
        reset = 1'b0;
        #1;
        chk("async_valido0", 32'(sai_valido0), 32'd0);
        chk("async_valido1", 32'(sai_valido1), 32'd0);
        chk("async_cont",    32'(cont0),       32'd0);
        sb.delete();
        @(posedge clock);
        #1;
        reset      = 1'b1;
        sai_pronto = 1'b1;
        repeat (3) begin
            @(negedge clock);
            chk("post_rst_idle", 32'(sai_valido0), 32'd0);
        end
        @(posedge clock);
        #1;
        send(tab[8]);
        drain();

        // Random round trip, mostly in-range values
        for (int i = 0; i < 24; i++) begin
            logic [31:0] r;
            logic        c;
            r = $urandom;
            c = 1'($urandom_range(0, 1));
            if (i % 4 != 3) r = c ? {{16{r[15]}}, r[15:0]} : {{11{r[20]}}, r[20:0]};
            send(modelo(r, c));
        end
        drain();

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
